// File: rtl/if_stage_pkg.sv
// Shared widths, bus layouts and reset PC for the instruction-fetch stage.
// The bench imports this as well, so the reset PC has a single source.
package if_stage_pkg;

    localparam int          IF_TO_ID_WD  = 64;
    localparam int          ID_TO_IF_WD  = 34;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_to_id_t;

    typedef struct packed {
        logic        br_taken;
        logic [31:0] br_target;
        logic        br_taken_cancel;
    } id_to_if_t;

endpackage

// File: rtl/if_stage.sv
// preIF next-PC select plus IF register; hands {pc, inst} to ID over valid/allowin.
// Instruction appears 1 cycle after its request; it is buffered locally while ID stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   id_allowin,
    output logic                   if_to_id_valid,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    input  logic [ID_TO_IF_WD-1:0] id_to_if_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_we,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata
);

    id_to_if_t   br;
    if_to_id_t   out_bus;

    logic [31:0] if_pc_q,     if_pc_d;
    logic        if_valid_q,  if_valid_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;
    logic        fresh_q,     fresh_d;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        pre_ready_go;
    logic        if_allowin;
    logic        fetch;
    logic        handover;
    logic        cancel;

    assign br     = id_to_if_t'(id_to_if_bus);
    assign cancel = br.br_taken_cancel;

    // A taken branch without cancel is still waiting on load-use; its target is not final yet.
    always_comb begin
        seq_pc       = if_pc_q + 32'd4;
        nextpc       = cancel ? br.br_target : seq_pc;
        pre_ready_go = ~(br.br_taken & ~cancel);
        if_allowin   = ~if_valid_q | id_allowin | cancel;
        fetch        = resetn & pre_ready_go & if_allowin;
        handover     = if_valid_q & id_allowin;
    end

    always_comb begin
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        fresh_d     = fetch;

        if (fetch) begin
            if_pc_d    = nextpc;
            if_valid_d = 1'b1;
        end else if (handover || cancel) begin
            if_valid_d = 1'b0;
        end

        // rdata is only trustworthy the cycle after the request, so capture it then if ID stalls.
        if (cancel || fetch || handover) begin
            buf_valid_d = 1'b0;
        end else if (fresh_q && if_valid_q && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            inst_buf_d  = inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_pc_q     <= RESET_PC - 32'd4;
            if_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= '0;
            fresh_q     <= 1'b0;
        end else begin
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
            fresh_q     <= fresh_d;
        end
    end

    assign out_bus.pc   = if_pc_q;
    assign out_bus.inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;

    assign if_to_id_valid  = if_valid_q & ~cancel;
    assign if_to_id_bus    = out_bus;
    assign inst_sram_en    = fetch;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios followed by randomized traffic,
// checked against a slot-level model of fetch and handover.
module tb_if_stage;
    import if_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   id_allowin;
    logic                   if_to_id_valid;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [ID_TO_IF_WD-1:0] id_to_if_bus;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_we;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [31:0]            inst_sram_rdata = 32'hdeadbeef;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC_DEF)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .id_allowin      (id_allowin),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_bus    (if_to_id_bus),
        .id_to_if_bus    (id_to_if_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h1234abcd;
    endfunction

    // Data is valid only the cycle after a request; otherwise the bus carries junk.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem(inst_sram_addr) : 32'hdeadbeef;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic        vld;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [63:0] hand_q[$];
    cyc_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_pc;
    logic        m_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, record what the stage must do this cycle, then advance the model.
    task automatic step(input logic r, input logic a, input logic b,
                        input logic [31:0] t, input logic c);
        logic        hand;
        logic        fetch;
        logic [31:0] nxt;
        cyc_t        e;
        resetn       = r;
        id_allowin   = a;
        id_to_if_bus = {b, t, c};
        hand  = m_valid & a & ~c;
        fetch = r & ~(b & ~c) & (~m_valid | hand | c);
        nxt   = c ? t : m_pc + 32'd4;
        e.en   = fetch;
        e.addr = nxt;
        e.vld  = m_valid & ~c;
        cyc_q.push_back(e);
        if (hand) hand_q.push_back({m_pc, mem(m_pc)});
        if (!r) begin
            m_pc    = RESET_PC_DEF - 32'd4;
            m_valid = 1'b0;
        end else if (fetch) begin
            m_pc    = nxt;
            m_valid = 1'b1;
        end else if (hand || c) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                check("sram_en", 64'(inst_sram_en), 64'(mon_e.en));
                if (mon_e.en) check("sram_addr", 64'(inst_sram_addr), 64'(mon_e.addr));
                check("if_to_id_valid", 64'(if_to_id_valid), 64'(mon_e.vld));
                check("sram_we_wdata", {28'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
            end
            if (if_to_id_valid === 1'b1 && id_allowin === 1'b1) begin
                if (hand_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL handover: got bus %h expected no handover", if_to_id_bus);
                end else begin
                    check("if_to_id_bus", if_to_id_bus, hand_q.pop_front());
                end
            end
        end
    end

    initial begin
        int k;
        logic r, a, b, c;
        logic [31:0] t;
        resetn       = 1'b0;
        id_allowin   = 1'b0;
        id_to_if_bus = '0;
        m_pc         = RESET_PC_DEF - 32'd4;
        m_valid      = 1'b0;
        @(posedge clk);
        #1;

        // Reset release and a 5-cycle stream.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Stall while IF holds 0x1c000008, then release.
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while IF holds 0x1c000010.
        step(1'b1, 1'b1, 1'b1, 32'h1c00_0100, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Branch held on load-use, then resolved.
        repeat (2) step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h1c00_0200, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Reset while a stalled instruction sits in the buffer.
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            r = ($urandom % 100) != 0;
            a = ($urandom % 4) != 0;
            k = $urandom % 10;
            b = (k <= 1);
            c = (k == 0);
            t = RESET_PC_DEF + {20'd0, 10'($urandom % 1024), 2'b00};
            step(r, a, b, t, c);
        end
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        check("pending_cycles", 64'(cyc_q.size()), 64'd0);
        check("pending_handovers", 64'(hand_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
